// File: rtl/updown_ctrl_if.sv
// updown_ctrl_if: raw buttons, divider reload and counter feedback in; tick,
// direction and status out. The master side drives buttons, the slave is updown_ctrl.
interface updown_ctrl_if #(
  parameter int DIV_W = 8
);
  logic             run_btn;
  logic             dir_btn;
  logic [DIV_W-1:0] div_load;
  logic [3:0]       count;
  logic             tick;
  logic             status;
  logic             running;
  logic             dir_chg;

  modport master (
    output run_btn, dir_btn, div_load, count,
    input  tick, status, running, dir_chg
  );

  modport slave (
    input  run_btn, dir_btn, div_load, count,
    output tick, status, running, dir_chg
  );
endinterface

// File: rtl/updown_ctrl.sv
// updown_ctrl: button sync/debounce, programmable tick divider FSM and direction
// control for the 4-bit ripple up/down counter. Define AUTO_REV_EN for terminal-count auto-reverse.
module updown_ctrl #(
  parameter int DIV_W     = 8,
  parameter int DB_CYCLES = 16,
  parameter int DB_W      = 5
) (
  input logic          clk,
  input logic          rst_n,
  updown_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN_LO,
    RUN_HI,
    STOP_PEND
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  // Bit 0 is the run button, bit 1 the direction button.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1;
  logic [1:0]      sync2;
  logic [1:0]      lvl;
  logic [1:0]      lvl_q;
  logic [1:0]      ev;
  logic [DB_W-1:0] db_cnt [2];

  state_t           state;
  state_t           state_nxt;
  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_nxt;
  logic             tick_q;
  logic             running_q;
  logic             status_q;
  logic             status_nxt;
  logic             dir_chg_q;
  logic             pend;
  logic             pend_nxt;
  logic             flip;
  logic             apply;
  logic             auto_rev;
  logic             run_ev;
  logic             dir_ev;

  assign btn_raw = {bus.dir_btn, bus.run_btn};
  assign ev      = lvl & ~lvl_q;
  assign run_ev  = ev[0];
  assign dir_ev  = ev[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      lvl   <= '0;
      lvl_q <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      lvl_q <= lvl;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == lvl[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          lvl[i]    <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

`ifdef AUTO_REV_EN
  assign auto_rev = status_q ? (bus.count == 4'd0) : (bus.count == 4'hF);
`else
  assign auto_rev = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    div_nxt   = div;
    apply     = 1'b0;
    case (state)
      IDLE: begin
        if (run_ev) begin
          state_nxt = RUN_LO;
          div_nxt   = bus.div_load;
        end
      end
      RUN_LO: begin
        if (run_ev) begin
          state_nxt = IDLE;
          apply     = 1'b1;
        end else if (div == '0) begin
          state_nxt = RUN_HI;
          div_nxt   = bus.div_load;
        end else begin
          div_nxt = div - 1'b1;
        end
      end
      RUN_HI: begin
        // A stop request landing on the fall edge itself finishes immediately.
        if (div == '0) begin
          state_nxt = run_ev ? IDLE : RUN_LO;
          div_nxt   = bus.div_load;
          apply     = 1'b1;
        end else begin
          div_nxt = div - 1'b1;
          if (run_ev) begin
            state_nxt = STOP_PEND;
          end
        end
      end
      STOP_PEND: begin
        if (div == '0) begin
          state_nxt = IDLE;
          apply     = 1'b1;
        end else begin
          div_nxt = div - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    pend_nxt = pend;
    flip     = 1'b0;
    if (state == IDLE) begin
      flip = dir_ev;
    end else if (apply) begin
      // Manual and auto-reverse requests on the same apply edge cancel.
      flip     = pend ^ dir_ev ^ auto_rev;
      pend_nxt = 1'b0;
    end else begin
      pend_nxt = pend ^ dir_ev;
    end
    status_nxt = status_q ^ flip;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div       <= '0;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
      status_q  <= 1'b0;
      dir_chg_q <= 1'b0;
      pend      <= 1'b0;
    end else begin
      state     <= state_nxt;
      div       <= div_nxt;
      tick_q    <= (state_nxt == RUN_HI) || (state_nxt == STOP_PEND);
      running_q <= (state_nxt == RUN_LO) || (state_nxt == RUN_HI);
      status_q  <= status_nxt;
      dir_chg_q <= flip;
      pend      <= pend_nxt;
    end
  end

  assign bus.tick    = tick_q;
  assign bus.running = running_q;
  assign bus.status  = status_q;
  assign bus.dir_chg = dir_chg_q;

endmodule

// File: doc/updown_ctrl.md
# updown_ctrl

Upstream control stage for the 4-bit ripple up/down counter. Synchronizes and debounces two raw push-button inputs (run/stop, direction), generates the counter's `tick` clock from the system clock with a programmable divider, and drives the counter's `status` direction line. `status` changes only while `tick` is low. An optional feedback path reverses direction automatically at the terminal count.

## Interface
- `DIV_W`, 8: width of the divider reload value.
- `DB_CYCLES`, 16: consecutive stable cycles required to accept a button level (≥2).
- `DB_W`, 5: debounce counter width; must hold `DB_CYCLES`.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run_btn`  in  1  raw asynchronous run/stop button, active-high.
- `dir_btn`  in  1  raw asynchronous direction button, active-high.
- `div_load`  in  DIV_W  half-period reload; sampled at each divider reload.
- `count`  in  4  counter value fed back; used only with `AUTO_REV_EN`.
- `tick`  out  1  clock to the ripple counter; registered.
- `status`  out  1  direction to the counter: 0 = up, 1 = down; registered.
- `running`  out  1  high while the FSM is in RUN_LO or RUN_HI.
- `dir_chg`  out  1  one-cycle pulse on the cycle `status` toggles.

## Operation
- Reset values: `tick`=0, `status`=0, `running`=0, `dir_chg`=0, FSM=IDLE, divider=0, debounced levels=0, dir-pending=0.
- Each button uses a 2-FF synchronizer followed by a debouncer. The debounced level updates only after the synchronized input differs from it for `DB_CYCLES` consecutive cycles. Any bounce restarts the count.
- A rising edge on debounced run produces a run event (one cycle). A rising edge on debounced dir produces a dir event.
- FSM states:
  - IDLE: `tick`=0. On a run event, go to RUN_LO and load the divider with `div_load`.
  - RUN_LO: `tick`=0. When the divider reaches 0, go to RUN_HI, set `tick`=1, and reload. Otherwise decrement.
  - RUN_HI: `tick`=1. When the divider reaches 0, go to RUN_LO, set `tick`=0, and reload. A run event here goes to STOP_PEND.
  - STOP_PEND: `tick`=1. When the divider reaches 0, go to IDLE with `tick`=0.
  - A run event in RUN_LO goes straight to IDLE.
- `tick` period = 2·(`div_load`+1) clk cycles. `div_load`=0 gives a period of 2. `tick` never produces a high phase shorter than `div_load`+1 cycles.
- Direction:
  - In IDLE, a dir event toggles `status` on the next edge.
  - In any other state, a dir event toggles dir-pending. Two events before the apply point cancel.
  - Pending changes are applied on the edge that drives `tick` 1→0, or on entry to IDLE.
  - `dir_chg` pulses with every `status` toggle.
- Simultaneous run and dir events: both are processed in the same cycle by the rules above.
- Reset asserted mid-run: all outputs drop to their reset values immediately, asynchronously. A `tick` truncated by reset is accepted.

## Timing
- Button press to debounced level: 2 (sync) + `DB_CYCLES` cycles. The event is seen in the following cycle.
- Run event in IDLE: `running`=1 on the next edge. The first `tick` rise comes `div_load`+1 cycles later.
- Stop request: takes effect at the next `tick` fall, with at most `div_load`+1 cycles of latency.
- `status` and `tick` never change on the same edge except on a 1→0 `tick` transition. This guarantees no spurious counter edge from `clk & status`.
- `count` is sampled on the cycle before a `tick` fall. This is ≥`div_load`+1 cycles after the rise, which covers the ripple settle time provided `div_load` ≥ 1.

## Configuration
- `AUTO_REV_EN` defined:
  - At the apply point, if `status`=0 and `count`=15, or `status`=1 and `count`=0, an auto-reverse request is XORed with dir-pending.
  - A manual request and an auto-reverse request at the same edge cancel: no toggle, no `dir_chg` pulse.
- `AUTO_REV_EN` undefined: `count` is ignored and the only source of direction change is `dir_btn`.

## Test plan
- Reset with both buttons low, `div_load`=3 → `tick`=0, `status`=0, `running`=0, `dir_chg`=0. Hold 50 cycles with no change.
- Run press held 30 cycles, `DB_CYCLES`=16 → `running` rises 19 cycles after the press. `tick` first rises 4 cycles later, then has period 8.
- Run press with a 5-cycle bounce train, then stable → only one run event. Debounce restarts on each bounce.
- While running, dir press applied mid-high phase → `status` toggles exactly on the `tick` 1→0 edge with a 1-cycle `dir_chg` pulse. Two presses within one period → no toggle.
- Stop press during RUN_HI → `tick` completes its high phase, then stays 0 and `running`=0. Assert `rst_n`=0 mid-high → `tick`=0 immediately.
- `AUTO_REV_EN`, `status`=0, drive `count`=15 → `status`=1 at the next `tick` fall. Same edge with a manual dir event → `status` stays 0 and there is no `dir_chg` pulse.
